// File: rtl/vproc_pkg.sv
// rtl/vproc_pkg.sv - shared vector processor configuration types
package vproc_pkg;

   typedef enum logic [2:0] {
      VSEW_8       = 3'b000,
      VSEW_16      = 3'b001,
      VSEW_32      = 3'b010,
      VSEW_64      = 3'b011,
      VSEW_INVALID = 3'b111
   } cfg_vsew;

endpackage

// File: rtl/vproc_elem_pack.sv
// rtl/vproc_elem_pack.sv - packs ELEM unit element results into vreg-wide write requests
module vproc_elem_pack
   import vproc_pkg::*;
#(
   parameter int unsigned VREG_W         = 128,
   parameter bit          DONT_CARE_ZERO = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  async_rst_ni,
   input  logic                  sync_rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  cfg_vsew               in_eew_i,
   input  logic                  in_first_i,
   input  logic                  in_last_i,
   input  logic                  in_res_valid_i,
   input  logic [31:0]           in_res_i,
   input  logic                  in_mask_i,
   input  logic [4:0]            in_vaddr_i,
   output logic                  wr_valid_o,
   input  logic                  wr_ready_i,
   output logic [4:0]            wr_addr_o,
   output logic [VREG_W-1:0]     wr_data_o,
   output logic [VREG_W/8-1:0]   wr_be_o
);

   localparam int unsigned NB = VREG_W / 8;
   localparam int unsigned PW = $clog2(NB);

   logic unused_dont_care_zero;
   assign unused_dont_care_zero = DONT_CARE_ZERO;

   logic [PW-1:0]     ptr_q;
   logic [2:0]        reg_cnt_q;
   logic [VREG_W-1:0] acc_data_q;
   logic [NB-1:0]     acc_be_q;

   logic              wr_valid_q;
   logic [4:0]        wr_addr_q;
   logic [VREG_W-1:0] wr_data_q;
   logic [NB-1:0]     wr_be_q;

   logic              accept;
   logic              eew_ok;
   logic [2:0]        elem_bytes;
   logic [PW-1:0]     ptr_base, ptr_nxt, lane;
   logic [2:0]        cnt_base;
   logic [VREG_W-1:0] data_ins;
   logic [NB-1:0]     be_ins;
   logic              full, emit;

   assign in_ready_o = ~wr_valid_q | wr_ready_i;
   assign accept     = in_valid_i & in_ready_o;

   // A first beat discards whatever a previous instruction left behind.
   always_comb begin
      elem_bytes = 3'd0;
      eew_ok     = 1'b1;
      case (in_eew_i)
         VSEW_8:  elem_bytes = 3'd1;
         VSEW_16: elem_bytes = 3'd2;
         VSEW_32: elem_bytes = 3'd4;
         default: eew_ok     = 1'b0;
      endcase

      ptr_base = in_first_i ? '0 : ptr_q;
      cnt_base = in_first_i ? '0 : reg_cnt_q;
      data_ins = in_first_i ? '0 : acc_data_q;
      be_ins   = in_first_i ? '0 : acc_be_q;
      ptr_nxt  = ptr_base;
      lane     = '0;

      if (in_res_valid_i && eew_ok) begin
         for (int k = 0; k < 4; k++) begin
            if (3'(k) < elem_bytes) begin
               lane = ptr_base + PW'(k);
               data_ins[{lane, 3'b000} +: 8] = in_res_i[k*8 +: 8];
               be_ins[lane]                  = in_mask_i;
            end
         end
         ptr_nxt = ptr_base + PW'(elem_bytes);
      end

      full = in_res_valid_i & eew_ok & (ptr_nxt == '0);
      emit = eew_ok & (full | (in_last_i & (ptr_nxt != '0)));
   end

   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         ptr_q      <= '0;
         reg_cnt_q  <= '0;
         acc_data_q <= '0;
         acc_be_q   <= '0;
      end else if (!sync_rst_ni) begin
         ptr_q      <= '0;
         reg_cnt_q  <= '0;
         acc_data_q <= '0;
         acc_be_q   <= '0;
      end else if (accept && eew_ok) begin
         if (emit) begin
            acc_data_q <= '0;
            acc_be_q   <= '0;
         end else begin
            acc_data_q <= data_ins;
            acc_be_q   <= be_ins;
         end
         if (in_last_i) begin
            ptr_q     <= '0;
            reg_cnt_q <= '0;
         end else begin
            ptr_q     <= ptr_nxt;
            reg_cnt_q <= emit ? cnt_base + 3'd1 : cnt_base;
         end
      end
   end

   // Retiring without a replacement zeroes the payload so idle outputs read 0.
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_be_q    <= '0;
      end else if (!sync_rst_ni) begin
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_be_q    <= '0;
      end else if (accept && emit) begin
         wr_valid_q <= 1'b1;
         wr_addr_q  <= in_vaddr_i + {2'b00, cnt_base};
         wr_data_q  <= data_ins;
         wr_be_q    <= be_ins;
      end else if (wr_ready_i) begin
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_be_q    <= '0;
      end
   end

   assign wr_valid_o = wr_valid_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign wr_be_o    = wr_be_q;

endmodule
